dmem_ctrl: RTL and testbench

//  Parametrised data-memory controller for the 5-stage pipeline; successor to the fixed single-cycle dm.

---
 rtl/dmem_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ctrl
//  Purpose  : Data-memory controller for the 5-stage pipeline MEM stage.
//             Byte/half/word loads and stores to an on-chip RAM with a
//             configurable read latency (pipeline stall handshake),
//             misalignment detection and a small MMIO window
//             (LED output register + switch input port).
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             req_valid/we/type/addr/wdata - request from the MEM stage
//             req_ready          - controller idle, request can be accepted
//             stall              - freeze IF..MEM while a load is pending
//             rsp_valid/rsp_rdata- one-cycle load result (rdata 0 otherwise)
//             misalign           - one-cycle pulse after a misaligned request
//             mmio_in / mmio_out - switch inputs / LED register
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
    parameter int          ADDR_W    = 10,
    parameter int          LAT       = 1,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          MMIO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              stall,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign,
    input  logic [MMIO_W-1:0] mmio_in,
    output logic [MMIO_W-1:0] mmio_out
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [2:0] c_T_WORD  = 3'b000;
    localparam logic [2:0] c_T_HALF  = 3'b001;
    localparam logic [2:0] c_T_HALFU = 3'b010;
    localparam logic [2:0] c_T_BYTE  = 3'b011;
    localparam logic [2:0] c_T_BYTEU = 3'b100;

    localparam int         c_DEPTH    = 2 ** ADDR_W;
    // BUSY lasts LAT-1 cycles; counter is loaded with LAT-2 and exits at 0.
    localparam logic [1:0] c_CNT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    logic [31:0]       r_mem [0:c_DEPTH-1];

    logic [1:0]        r_state;
    logic [1:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_lo;
    logic [2:0]        r_type;
    logic              r_is_mmio;
    logic              r_is_base;
    logic [MMIO_W-1:0] r_mmio_in;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_misalign;
    logic [MMIO_W-1:0] r_mmio_out;

    logic              w_is_mmio;
    logic              w_is_base;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_ld_go;
    logic              w_st_go;
    logic              w_enter_resp;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [ADDR_W-1:0] w_req_idx;
    logic [31:0]       w_ram_old;
    logic [31:0]       w_ram_merge;
    logic [MMIO_W-1:0] w_mmio_next;
    logic [ADDR_W-1:0] w_src_idx;
    logic [1:0]        w_src_lo;
    logic [2:0]        w_src_type;
    logic              w_src_mmio;
    logic              w_src_base;
    logic [MMIO_W-1:0] w_src_mmio_in;
    logic [31:0]       w_src_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;

    assign w_is_mmio = (req_addr[31:16] == MMIO_BASE[31:16]);
    assign w_is_base = w_is_mmio && (req_addr[31:2] == MMIO_BASE[31:2]);
    assign w_req_idx = req_addr[ADDR_W+1:2];

    always_comb begin
        w_misaligned = 1'b0;
        case (req_type)
            c_T_HALF, c_T_HALFU: w_misaligned = req_addr[0];
            c_T_BYTE, c_T_BYTEU: w_misaligned = 1'b0;
            default:             w_misaligned = (req_addr[1:0] != 2'b00);
        endcase
    end

    assign w_accept = req_valid && (r_state == c_ST_IDLE) && !rst;
    assign w_ld_go  = w_accept && !req_we && !w_misaligned;
    assign w_st_go  = w_accept &&  req_we && !w_misaligned;

    // Store lane enables and lane-replicated store data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_type)
            c_T_HALF, c_T_HALFU: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            c_T_BYTE, c_T_BYTEU: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Byte-enabled merge of store data into the addressed RAM word.
    assign w_ram_old = r_mem[w_req_idx];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ram_lane
            assign w_ram_merge[8*g+7:8*g] = w_be[g] ? w_wdata[8*g+7:8*g]
                                                    : w_ram_old[8*g+7:8*g];
        end
        for (g = 0; g < MMIO_W; g++) begin : g_mmio_bit
            assign w_mmio_next[g] = w_be[g/8] ? w_wdata[g] : r_mmio_out[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_st_go && !w_is_mmio) begin
            r_mem[w_req_idx] <= w_ram_merge;
        end
    end

    // The load result is registered on the edge that enters RESP. With LAT=1
    // that is the accept edge itself, so the live request fields are used
    // while idle and the latched ones afterwards. No store can be accepted
    // in between, so RAM/LED contents are stable across the wait.
    assign w_enter_resp = (r_state == c_ST_IDLE) ? (w_ld_go && (LAT == 1))
                                                 : ((r_state == c_ST_BUSY) && (r_cnt == 2'd0));

    assign w_src_idx     = (r_state == c_ST_IDLE) ? w_req_idx     : r_idx;
    assign w_src_lo      = (r_state == c_ST_IDLE) ? req_addr[1:0] : r_lo;
    assign w_src_type    = (r_state == c_ST_IDLE) ? req_type      : r_type;
    assign w_src_mmio    = (r_state == c_ST_IDLE) ? w_is_mmio     : r_is_mmio;
    assign w_src_base    = (r_state == c_ST_IDLE) ? w_is_base     : r_is_base;
    assign w_src_mmio_in = (r_state == c_ST_IDLE) ? mmio_in       : r_mmio_in;

    assign w_src_word = w_src_mmio ? (w_src_base ? 32'(r_mmio_out) : 32'(w_src_mmio_in))
                                   : r_mem[w_src_idx];

    always_comb begin
        w_byte = w_src_word[7:0];
        case (w_src_lo)
            2'd1:    w_byte = w_src_word[15:8];
            2'd2:    w_byte = w_src_word[23:16];
            2'd3:    w_byte = w_src_word[31:24];
            default: w_byte = w_src_word[7:0];
        endcase
        w_half = w_src_lo[1] ? w_src_word[31:16] : w_src_word[15:0];
        case (w_src_type)
            c_T_HALF:  w_ext = {{16{w_half[15]}}, w_half};
            c_T_HALFU: w_ext = {16'd0, w_half};
            c_T_BYTE:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_T_BYTEU: w_ext = {24'd0, w_byte};
            default:   w_ext = w_src_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 2'd0;
            r_idx       <= '0;
            r_lo        <= 2'd0;
            r_type      <= c_T_WORD;
            r_is_mmio   <= 1'b0;
            r_is_base   <= 1'b0;
            r_mmio_in   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_misalign  <= 1'b0;
            r_mmio_out  <= '0;
        end else begin
            r_misalign  <= w_accept && w_misaligned;
            r_rsp_valid <= w_enter_resp;
            r_rsp_rdata <= w_enter_resp ? w_ext : 32'd0;
            if (w_st_go && w_is_base) begin
                r_mmio_out <= w_mmio_next;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_ld_go) begin
                        r_idx     <= w_req_idx;
                        r_lo      <= req_addr[1:0];
                        r_type    <= req_type;
                        r_is_mmio <= w_is_mmio;
                        r_is_base <= w_is_base;
                        r_mmio_in <= mmio_in;
                        r_cnt     <= c_CNT_INIT;
                        r_state   <= (LAT > 1) ? c_ST_BUSY : c_ST_RESP;
                    end
                end
                c_ST_BUSY: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                c_ST_RESP: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == c_ST_IDLE);
    assign stall     = w_ld_go || (r_state == c_ST_BUSY);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign misalign  = r_misalign;
    assign mmio_out  = r_mmio_out;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_ctrl
//  Purpose  : Self-checking bench for dmem_ctrl. Instance A (LAT=2) covers
//             stores, extended loads, misalignment, MMIO and address wrap;
//             instance B (LAT=4) covers reset during an in-flight load.
//             Load results go through an expected-value queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

    localparam int          LAT_A  = 2;
    localparam int          LAT_B  = 4;
    localparam logic [31:0] MBASE  = 32'hFFFF_0000;
    localparam logic [2:0]  T_W    = 3'b000;
    localparam logic [2:0]  T_H    = 3'b001;
    localparam logic [2:0]  T_HU   = 3'b010;
    localparam logic [2:0]  T_B    = 3'b011;
    localparam logic [2:0]  T_BU   = 3'b100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A
    logic        a_rst, a_req_valid, a_req_we;
    logic [2:0]  a_req_type;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [15:0] a_mmio_in;
    logic        a_req_ready, a_stall, a_rsp_valid, a_misalign;
    logic [31:0] a_rsp_rdata;
    logic [15:0] a_mmio_out;

    // Instance B
    logic        b_rst, b_req_valid, b_req_we;
    logic [2:0]  b_req_type;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [15:0] b_mmio_in;
    logic        b_req_ready, b_stall, b_rsp_valid, b_misalign;
    logic [31:0] b_rsp_rdata;
    logic [15:0] b_mmio_out;

    dmem_ctrl #(.ADDR_W(10), .LAT(LAT_A), .MMIO_BASE(MBASE), .MMIO_W(16)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .req_valid(a_req_valid), .req_we(a_req_we), .req_type(a_req_type),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .req_ready(a_req_ready), .stall(a_stall),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .misalign(a_misalign),
        .mmio_in(a_mmio_in), .mmio_out(a_mmio_out)
    );

    dmem_ctrl #(.ADDR_W(10), .LAT(LAT_B), .MMIO_BASE(MBASE), .MMIO_W(16)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_type(b_req_type),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .req_ready(b_req_ready), .stall(b_stall),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .misalign(b_misalign),
        .mmio_in(b_mmio_in), .mmio_out(b_mmio_out)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb_q[$];
    int          b_rsp_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every response from A is compared against the oldest
    // expected load result.
    always @(negedge clk) begin
        if (a_rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(sb_q.size()), 32'd1);
            end else begin
                check("rsp_data", a_rsp_rdata, sb_q.pop_front());
            end
        end
        if (b_rsp_valid === 1'b1) begin
            b_rsp_seen++;
        end
    end

    task automatic store_a(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] data);
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_we = 1'b1;
        a_req_addr  = addr; a_req_type = typ; a_req_wdata = data;
        @(negedge clk);
        check("st_stall", 32'(a_stall), 32'd0);
        check("st_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
    endtask

    // Request is held (with a corrupted address and new switch value) while
    // the controller is busy; none of that may affect the pending load.
    task automatic load_a(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] exp);
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_we = 1'b0;
        a_req_addr  = addr; a_req_type = typ; a_req_wdata = $urandom;
        sb_q.push_back(exp);
        for (int c = 0; c < LAT_A; c++) begin
            @(negedge clk);
            check("ld_stall", 32'(a_stall), 32'd1);
            @(posedge clk); #1;
            a_req_addr = addr ^ 32'h0000_0004;
            a_mmio_in  = 16'($urandom);
        end
        @(negedge clk);
        check("ld_rsp_valid", 32'(a_rsp_valid), 32'd1);
        check("ld_rsp_stall", 32'(a_stall), 32'd0);
        check("ld_rsp_ready", 32'(a_req_ready), 32'd0);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        check("ld_after_valid", 32'(a_rsp_valid), 32'd0);
        check("ld_after_rdata", a_rsp_rdata, 32'd0);
    endtask

    task automatic misalign_a(input logic [31:0] addr, input logic [2:0] typ, input logic we);
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_we = we;
        a_req_addr  = addr; a_req_type = typ; a_req_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("mis_stall", 32'(a_stall), 32'd0);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        check("mis_pulse", 32'(a_misalign), 32'd1);
        check("mis_rsp", 32'(a_rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mis_pulse_end", 32'(a_misalign), 32'd0);
    endtask

    initial begin
        a_rst = 1'b1; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_type = T_W;
        a_req_addr = 32'd0; a_req_wdata = 32'd0; a_mmio_in = 16'd0;
        b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_type = T_W;
        b_req_addr = 32'd0; b_req_wdata = 32'd0; b_mmio_in = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(a_req_ready), 32'd1);
        check("rst_stall", 32'(a_stall), 32'd0);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_rdata", a_rsp_rdata, 32'd0);
        check("rst_misalign", 32'(a_misalign), 32'd0);
        check("rst_mmio_out", 32'(a_mmio_out), 32'd0);

        // Word store/load round trip
        store_a(32'h0000_0010, T_W, 32'hDEAD_BEEF);
        load_a (32'h0000_0010, T_W, 32'hDEAD_BEEF);

        // Byte store into lane 3, then extended loads
        store_a(32'h0000_0013, T_B,  32'h1234_5680);
        load_a (32'h0000_0013, T_B,  32'hFFFF_FF80);
        load_a (32'h0000_0013, T_BU, 32'h0000_0080);
        load_a (32'h0000_0012, T_H,  32'hFFFF_80AD);
        load_a (32'h0000_0012, T_HU, 32'h0000_80AD);
        load_a (32'h0000_0010, T_W,  32'h80AD_BEEF);

        // Misaligned requests leave memory untouched
        misalign_a(32'h0000_0011, T_H, 1'b1);
        misalign_a(32'h0000_0012, T_W, 1'b0);
        load_a (32'h0000_0010, T_W, 32'h80AD_BEEF);

        // Half stores into both halves of a word
        store_a(32'h0000_0014, T_H, 32'hAAAA_1234);
        store_a(32'h0000_0016, T_H, 32'hBBBB_5678);
        load_a (32'h0000_0014, T_W, 32'h5678_1234);

        // MMIO
        store_a(MBASE, T_W, 32'h0000_00A5);
        @(negedge clk);
        check("mmio_out_sw", 32'(a_mmio_out), 32'h0000_00A5);
        store_a(MBASE + 32'd8, T_W, 32'hFFFF_FFFF);
        @(negedge clk);
        check("mmio_out_drop", 32'(a_mmio_out), 32'h0000_00A5);
        store_a(MBASE + 32'd1, T_B, 32'h0000_003C);
        @(negedge clk);
        check("mmio_out_sb", 32'(a_mmio_out), 32'h0000_3CA5);
        load_a (MBASE, T_W, 32'h0000_3CA5);
        a_mmio_in = 16'h1234;
        load_a (MBASE + 32'd4, T_W, 32'h0000_1234);

        // Address wrap modulo 4 KiB with ADDR_W=10
        store_a(32'h0000_1000, T_W, 32'h5A5A_5A5A);
        load_a (32'h0000_0000, T_W, 32'h5A5A_5A5A);

        // Instance B: reset in cycle 2 of a LAT=4 load
        @(posedge clk); #1;
        b_req_valid = 1'b1; b_req_addr = 32'h0000_0020; b_req_type = T_W;
        @(negedge clk);
        check("b_stall_c0", 32'(b_stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b_stall_c1", 32'(b_stall), 32'd1);
        @(posedge clk); #1;
        b_rst = 1'b1; b_req_valid = 1'b0;
        @(posedge clk); #1;
        b_rst = 1'b0;
        @(negedge clk);
        check("b_rst_stall", 32'(b_stall), 32'd0);
        check("b_rst_ready", 32'(b_req_ready), 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("b_no_rsp", 32'(b_rsp_seen), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
